cernbe_bus_master: RTL and testbench

- Initiator for the CERN-BE style memory bus, i.e. the end of the bus that drives VMEAddr, VMEWrData, VMERdMem and VMEWrMem, and waits for VMERdDone/VMEWrDone from a generated register-bank responder.
- Converts a valid/ready command stream from local logic (test sequencer, housekeeping FSM, bridge) into single bus cycles.
- Returns read data or a timeout error on a valid/ready response stream.
- One outstanding transaction at a time.

---
 rtl/cernbe_bus_master.sv | 161 ++++++++++++++++
 tb/tb_cernbe_bus_master.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cernbe_bus_master.sv
// Single-outstanding initiator for the CERN-BE memory bus: valid/ready commands in, responses out.
// Define CERNBE_BUS_MASTER_STATS_EN to add saturating read/write/timeout counters with stat_clr.
module cernbe_bus_master #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:1] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:1] VMEAddr,
    output logic [DATA_WIDTH-1:0] VMEWrData,
    output logic                  VMERdMem,
    output logic                  VMEWrMem,
    input  logic [DATA_WIDTH-1:0] VMERdData,
    input  logic                  VMERdDone,
    input  logic                  VMEWrDone
`ifdef CERNBE_BUS_MASTER_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [15:0]           stat_rd_cnt,
    output logic [15:0]           stat_wr_cnt,
    output logic [15:0]           stat_to_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t                  state, state_nxt;
    logic                    we_q, we_nxt;
    logic [15:0]             to_cnt, to_cnt_nxt;
    logic                    cmd_ready_nxt, busy_nxt;
    logic                    rsp_valid_nxt, rsp_err_nxt;
    logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;
    logic [ADDR_WIDTH-1:1]   addr_nxt;
    logic [DATA_WIDTH-1:0]   wrdata_nxt;
    logic                    rdmem_nxt, wrmem_nxt;
    logic                    done_match;

    // Only the completion matching the latched direction is honoured.
    assign done_match = we_q ? VMEWrDone : VMERdDone;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            to_cnt    <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            VMEAddr   <= '0;
            VMEWrData <= '0;
            VMERdMem  <= 1'b0;
            VMEWrMem  <= 1'b0;
        end else begin
            state     <= state_nxt;
            we_q      <= we_nxt;
            to_cnt    <= to_cnt_nxt;
            cmd_ready <= cmd_ready_nxt;
            busy      <= busy_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            VMEAddr   <= addr_nxt;
            VMEWrData <= wrdata_nxt;
            VMERdMem  <= rdmem_nxt;
            VMEWrMem  <= wrmem_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        we_nxt        = we_q;
        to_cnt_nxt    = to_cnt;
        rsp_valid_nxt = rsp_valid;
        rsp_err_nxt   = rsp_err;
        rsp_rdata_nxt = rsp_rdata;
        addr_nxt      = VMEAddr;
        wrdata_nxt    = VMEWrData;
        rdmem_nxt     = 1'b0;
        wrmem_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_nxt  = STROBE;
                    we_nxt     = cmd_we;
                    addr_nxt   = cmd_addr;
                    wrdata_nxt = cmd_we ? cmd_wdata : '0;
                    wrmem_nxt  = cmd_we;
                    rdmem_nxt  = !cmd_we;
                end
            end
            STROBE: begin
                to_cnt_nxt = '0;
                state_nxt  = WAIT;
            end
            WAIT: begin
                // A completion in the last allowed cycle still wins over the timeout.
                if (done_match) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = we_q ? '0 : VMERdData;
                    state_nxt     = RESP;
                end else if (to_cnt == TO_LAST) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                    state_nxt     = RESP;
                end else begin
                    to_cnt_nxt = to_cnt + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        cmd_ready_nxt = (state_nxt == IDLE);
        busy_nxt      = (state_nxt != IDLE);
    end

`ifdef CERNBE_BUS_MASTER_STATS_EN
    logic evt_rd, evt_wr, evt_to;

    assign evt_rd = (state == WAIT) && !we_q && VMERdDone;
    assign evt_wr = (state == WAIT) && we_q && VMEWrDone;
    assign evt_to = (state == WAIT) && !done_match && (to_cnt == TO_LAST);

    // Clear wins over a same-cycle event; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
            stat_to_cnt <= '0;
        end else begin
            if (evt_rd && stat_rd_cnt != 16'hFFFF) stat_rd_cnt <= stat_rd_cnt + 16'd1;
            if (evt_wr && stat_wr_cnt != 16'hFFFF) stat_wr_cnt <= stat_wr_cnt + 16'd1;
            if (evt_to && stat_to_cnt != 16'hFFFF) stat_to_cnt <= stat_to_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cernbe_bus_master.sv
// Self-checking bench for cernbe_bus_master: directed vector table, randomized transactions
// against a latency/outcome model, plus hand-written back-to-back and mid-transaction reset sequences.
module tb_cernbe_bus_master;

    localparam int AW = 2;
    localparam int DW = 16;
    localparam int TIMEOUT = 8;

    typedef struct {
        bit            we;
        logic [AW-1:1] addr;
        logic [DW-1:0] wdata;
        int            doneDelay;
        logic [DW-1:0] rdata;
        int            wrongDelay;
        bit            earlyDone;
        int            readyHold;
        int            strayAt;
        bit            expErr;
        logic [DW-1:0] expRdata;
        int            expLat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:1] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, busy;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:1] VMEAddr;
    logic [DW-1:0] VMEWrData, VMERdData;
    logic          VMERdMem, VMEWrMem, VMERdDone, VMEWrDone;
`ifdef CERNBE_BUS_MASTER_STATS_EN
    logic          stat_clr;
    logic [15:0]   stat_rd_cnt, stat_wr_cnt, stat_to_cnt;
`endif

    int checks = 0;
    int failures = 0;

    cernbe_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
        .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone)
`ifdef CERNBE_BUS_MASTER_STATS_EN
        ,
        .stat_clr(stat_clr), .stat_rd_cnt(stat_rd_cnt),
        .stat_wr_cnt(stat_wr_cnt), .stat_to_cnt(stat_to_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(bit we, logic [AW-1:1] addr, logic [DW-1:0] wdata, int doneDelay,
                                   logic [DW-1:0] rdata, int wrongDelay, bit earlyDone, int readyHold,
                                   int strayAt, bit expErr, logic [DW-1:0] expRdata, int expLat);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.doneDelay = doneDelay; v.rdata = rdata;
        v.wrongDelay = wrongDelay; v.earlyDone = earlyDone; v.readyHold = readyHold;
        v.strayAt = strayAt; v.expErr = expErr; v.expRdata = expRdata; v.expLat = expLat;
        return v;
    endfunction

    // Outcome model: completion within TIMEOUT wait cycles answers one cycle after Done,
    // otherwise an error appears one cycle after the last allowed wait cycle.
    function automatic vec_t refModel(input vec_t v);
        vec_t r = v;
        if (v.doneDelay >= 1 && v.doneDelay <= TIMEOUT) begin
            r.expErr = 1'b0;
            r.expRdata = v.we ? '0 : v.rdata;
            r.expLat = v.doneDelay + 1;
        end else begin
            r.expErr = 1'b1;
            r.expRdata = '0;
            r.expLat = TIMEOUT + 1;
        end
        return r;
    endfunction

    task automatic driveDone(input vec_t v, input int c);
        VMERdDone = 1'b0;
        VMEWrDone = 1'b0;
        VMERdData = 16'($urandom);
        if ((c > 0 && c == v.doneDelay) || (c == 0 && v.earlyDone)) begin
            if (v.we) VMEWrDone = 1'b1;
            else begin
                VMERdDone = 1'b1;
                VMERdData = v.rdata;
            end
        end
        if (c > 0 && c == v.wrongDelay) begin
            if (v.we) VMERdDone = 1'b1;
            else VMEWrDone = 1'b1;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int guard = 0;
        int lat = 0;
        int strobes = 0;
        bit heldOk = 1'b1;
        bit holdOk = 1'b1;
        logic [DW-1:0] expWd = v.we ? v.wdata : '0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_addr = 1'($urandom); cmd_wdata = 16'($urandom);
        checkOutput("strobe_wr", 32'(VMEWrMem), 32'(v.we));
        checkOutput("strobe_rd", 32'(VMERdMem), 32'(!v.we));
        checkOutput("strobe_addr", 32'(VMEAddr), 32'(v.addr));
        checkOutput("strobe_wdata", 32'(VMEWrData), 32'(expWd));
        checkOutput("strobe_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("strobe_busy", 32'(busy), 32'd1);
        driveDone(v, 0);
        for (int c = 1; c <= TIMEOUT + 4 && lat == 0; c++) begin
            @(negedge clk);
            if (VMERdMem || VMEWrMem) strobes++;
            if (rsp_valid) lat = c;
            else begin
                if (VMEAddr !== v.addr || VMEWrData !== expWd) heldOk = 1'b0;
                driveDone(v, c);
            end
        end
        VMERdDone = 1'b0; VMEWrDone = 1'b0;
        checkOutput("extra_strobes", 32'(strobes), 32'd0);
        checkOutput("bus_held", 32'(heldOk), 32'd1);
        checkOutput("rsp_latency", 32'(lat), 32'(v.expLat));
        checkOutput("rsp_err", 32'(rsp_err), 32'(v.expErr));
        checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(v.expRdata));
        for (int h = 1; h <= v.readyHold; h++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_err !== v.expErr || rsp_rdata !== v.expRdata ||
                cmd_ready !== 1'b0 || VMERdMem || VMEWrMem || busy !== 1'b1) holdOk = 1'b0;
            VMERdDone = (h == v.strayAt) && !v.we;
            VMEWrDone = (h == v.strayAt) && v.we;
            VMERdData = 16'($urandom);
        end
        if (v.readyHold > 0) checkOutput("rsp_hold", 32'(holdOk), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        VMERdDone = 1'b0; VMEWrDone = 1'b0;
        checkOutput("rsp_released", 32'(rsp_valid), 32'd0);
        checkOutput("ready_again", 32'(cmd_ready), 32'd1);
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] resetVector();
        return 32'({cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, VMEAddr, VMEWrData[7:0],
                    VMEWrData[15:8] != 8'h0, VMERdMem, VMEWrMem});
    endfunction

    vec_t vecs[9];

    initial begin
        int nStrobe, last, guard;
        bit gapOk, pend, rdSeen;
        vec_t r;

        vecs[0] = mkVec(1, 1'b1, 16'hA5C3, 1, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 2);
        vecs[1] = mkVec(0, 1'b0, 16'h0000, 1, 16'h1234, 0, 0, 0, 0, 0, 16'h1234, 2);
        vecs[2] = mkVec(0, 1'b1, 16'h0000, 0, 16'h0000, 0, 0, 6, 3, 1, 16'h0000, 9);
        vecs[3] = mkVec(0, 1'b0, 16'h0000, 2, 16'hBEEF, 0, 1, 0, 0, 0, 16'hBEEF, 3);
        vecs[4] = mkVec(1, 1'b0, 16'h5A5A, 5, 16'h0000, 3, 0, 0, 0, 0, 16'h0000, 6);
        vecs[5] = mkVec(1, 1'b1, 16'h0F0F, 4, 16'h0000, 0, 0, 10, 0, 0, 16'h0000, 5);
        vecs[6] = mkVec(0, 1'b1, 16'h0000, 8, 16'hCAFE, 2, 0, 0, 0, 0, 16'hCAFE, 9);
        vecs[7] = mkVec(1, 1'b0, 16'hFFFF, 0, 16'h0000, 0, 0, 2, 1, 1, 16'h0000, 9);
        vecs[8] = mkVec(0, 1'b1, 16'h0000, 1, 16'h0001, 0, 1, 0, 0, 0, 16'h0001, 2);

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; VMERdData = '0; VMERdDone = 1'b0; VMEWrDone = 1'b0;
`ifdef CERNBE_BUS_MASTER_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", resetVector(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);

        $display("[TB] directed vectors");
        foreach (vecs[i]) applyStimulus(vecs[i]);

        $display("[TB] back-to-back writes");
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 1'b1; cmd_wdata = 16'h3C3C; rsp_ready = 1'b1;
        pend = 1'b0; nStrobe = 0; last = -1; gapOk = 1'b1; rdSeen = 1'b0;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            VMEWrDone = pend;
            pend = 1'b0;
            if (VMERdMem) rdSeen = 1'b1;
            if (VMEWrMem) begin
                if (last >= 0 && c - last != 4) gapOk = 1'b0;
                last = c;
                nStrobe++;
                pend = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            VMEWrDone = pend;
            pend = 1'b0;
            guard++;
        end while ((busy || !cmd_ready) && guard < 20);
        VMEWrDone = 1'b0; rsp_ready = 1'b0;
        checkOutput("b2b_strobes", 32'(nStrobe), 32'd5);
        checkOutput("b2b_period", 32'(gapOk), 32'd1);
        checkOutput("b2b_no_rd", 32'(rdSeen), 32'd0);
        checkOutput("b2b_drained", 32'(busy), 32'd0);

        $display("[TB] reset during wait");
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("rst_seq_strobe", 32'(VMERdMem), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_mid_wait", resetVector(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rerst", 32'(cmd_ready), 32'd1);
        applyStimulus(mkVec(0, 1'b1, 16'h0000, 3, 16'h7E57, 0, 0, 0, 0, 0, 16'h7E57, 4));

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            r.we = 1'($urandom);
            r.addr = 1'($urandom);
            r.wdata = 16'($urandom);
            r.rdata = 16'($urandom);
            r.doneDelay = $urandom_range(0, TIMEOUT + 2);
            r.wrongDelay = $urandom_range(0, TIMEOUT);
            r.earlyDone = 1'($urandom);
            r.readyHold = $urandom_range(0, 3);
            r.strayAt = $urandom_range(0, r.readyHold);
            applyStimulus(refModel(r));
        end

`ifdef CERNBE_BUS_MASTER_STATS_EN
        $display("[TB] statistics counters");
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        checkOutput("stat_cleared0", 32'({stat_rd_cnt, stat_wr_cnt} | 32'(stat_to_cnt)), 32'd0);
        applyStimulus(mkVec(1, 1'b0, 16'h1111, 1, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 2));
        applyStimulus(mkVec(1, 1'b1, 16'h2222, 2, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 3));
        applyStimulus(mkVec(0, 1'b0, 16'h0000, 1, 16'h4321, 0, 0, 0, 0, 0, 16'h4321, 2));
        applyStimulus(mkVec(0, 1'b1, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 9));
        checkOutput("stat_wr", 32'(stat_wr_cnt), 32'd2);
        checkOutput("stat_rd", 32'(stat_rd_cnt), 32'd1);
        checkOutput("stat_to", 32'(stat_to_cnt), 32'd1);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        checkOutput("stat_cleared", 32'({stat_rd_cnt, stat_wr_cnt} | 32'(stat_to_cnt)), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
